// File: rtl/afifo_wr_arbiter_if.sv
// rtl/afifo_wr_arbiter_if.sv - requester/FIFO-side bus of the write-port arbiter
interface afifo_wr_arbiter_if #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8
) ();
  logic [NumReq-1:0]           Req;
  logic [NumReq*DataWidth-1:0] ReqData;
  logic                        FIFOfull;
  logic                        WRreq;
  logic [DataWidth-1:0]        WRdata;
  logic [NumReq-1:0]           Grant;
  logic [NumReq-1:0]           Ack;

  modport master (output Req, ReqData, FIFOfull, input WRreq, WRdata, Grant, Ack);
  modport slave  (input Req, ReqData, FIFOfull, output WRreq, WRdata, Grant, Ack);
endinterface

// File: rtl/afifo_wr_arbiter.sv
// rtl/afifo_wr_arbiter.sv - round-robin burst arbiter for the async FIFO write port
// Grant is registered; WRreq/WRdata/Ack are combinational from Grant and the live requests.
module afifo_wr_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8,
  parameter int MaxBurst  = 4
) (
  input logic               WRclk,
  input logic               reset,
  afifo_wr_arbiter_if.slave bus
);
  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(MaxBurst + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]           state;
  logic [NumReq-1:0]    grant;
  logic [PtrW-1:0]      ptr;
  logic [CntW-1:0]      cnt;

  logic [PtrW-1:0]      owner;
  logic [PtrW-1:0]      owner_next_ptr;
  logic [PtrW-1:0]      scan_start;
  logic [DataWidth-1:0] wr_data;
  logic [NumReq-1:0]    ack;
  logic [NumReq-1:0]    masked;
  logic [NumReq-1:0]    cand;
  logic [NumReq-1:0]    pick_onehot;
  logic [CntW-1:0]      cnt_inc;
  logic                 accept;
  logic                 owner_req;
  logic                 burst_done;
  logic                 rel;
  logic                 pick_valid;

  always_comb begin
    owner   = '0;
    wr_data = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant[i]) begin
        owner   = PtrW'(i);
        wr_data = wr_data | bus.ReqData[i*DataWidth +: DataWidth];
      end
    end
  end

  assign owner_next_ptr = (owner == PtrW'(NumReq - 1)) ? '0 : owner + PtrW'(1);
  assign ack        = grant & bus.Req & {NumReq{~bus.FIFOfull}};
  assign accept     = |ack;
  assign owner_req  = |(grant & bus.Req);
  assign cnt_inc    = cnt + CntW'(1);
  assign burst_done = accept && (cnt_inc == CntW'(MaxBurst));
  assign rel        = (state == BURST) && (burst_done || !owner_req);

  // Owner is masked out of the re-pick; a lone owner that exhausted its burst may win again.
  assign masked     = bus.Req & ~grant;
  assign cand       = ((masked != '0) || !burst_done) ? masked : bus.Req;
  assign scan_start = (state == IDLE) ? ptr : owner_next_ptr;

  always_comb begin
    int               idx;
    logic [PtrW-1:0]  sel;
    pick_onehot = '0;
    pick_valid  = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int k = 0; k < NumReq; k++) begin
      idx = int'(scan_start) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      sel = PtrW'(idx);
      if (!pick_valid && cand[sel]) begin
        pick_valid       = 1'b1;
        pick_onehot[sel] = 1'b1;
      end
    end
  end

  always_ff @(posedge WRclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant <= pick_onehot;
            cnt   <= '0;
            state <= BURST;
          end
        end
        default: begin
          if (rel) begin
            ptr <= owner_next_ptr;
            cnt <= '0;
            if (pick_valid) begin
              grant <= pick_onehot;
            end else begin
              grant <= '0;
              state <= IDLE;
            end
          end else if (accept) begin
            cnt <= cnt_inc;
          end
        end
      endcase
    end
  end

  assign bus.WRreq  = owner_req;
  assign bus.WRdata = wr_data;
  assign bus.Grant  = grant;
  assign bus.Ack    = ack;
endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// tb/tb_afifo_wr_arbiter.sv - directed and randomized bench for afifo_wr_arbiter
module tb_afifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic WRclk;
  logic reset;

  afifo_wr_arbiter_if #(.NumReq(N), .DataWidth(W)) bus ();

  afifo_wr_arbiter #(.NumReq(N), .DataWidth(W), .MaxBurst(MB)) dut (
    .WRclk (WRclk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial WRclk = 1'b0;
  always #5 WRclk = ~WRclk;

  int n_cmp;
  int n_err;

  // Requesters: each holds a number of words left to send and its current word.
  int         rem[N];
  logic [W-1:0] dat[N];
  int         ack_cnt[N];
  logic [N-1:0] req_v;
  logic [N-1:0] ack_obs;

  // Reference model: owner index (-1 when idle), pointer, words accepted in this grant.
  int m_owner, m_ptr, m_cnt;
  int nx_owner, nx_ptr, nx_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int scan(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic bit busy();
    bit b;
    b = (m_owner >= 0);
    for (int i = 0; i < N; i++) if (rem[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_next(input logic [N-1:0] r, input logic full);
    bit acc;
    bit done;
    logic [N-1:0] others;
    nx_owner = m_owner;
    nx_ptr   = m_ptr;
    nx_cnt   = m_cnt;
    if (m_owner < 0) begin
      if (r != '0) begin
        nx_owner = scan(r, m_ptr);
        nx_cnt   = 0;
      end
    end else begin
      acc  = r[m_owner] && !full;
      done = acc && (m_cnt + 1 == MB);
      if (done || !r[m_owner]) begin
        nx_ptr = (m_owner + 1) % N;
        nx_cnt = 0;
        others = r;
        others[m_owner] = 1'b0;
        nx_owner = scan(others, nx_ptr);
        if (nx_owner < 0 && done) nx_owner = m_owner;
      end else if (acc) begin
        nx_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_v[i] = (rem[i] > 0);
      bus.ReqData[i*W +: W] = dat[i];
    end
    bus.Req = req_v;
  endtask

  task automatic tick_pre();
    logic [N-1:0] eg;
    logic [N-1:0] ea;
    logic         ew;
    logic [W-1:0] ed;
    drive();
    #1;
    eg = '0;
    ew = 1'b0;
    ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ew = req_v[m_owner];
      ed = dat[m_owner];
    end
    ea = (ew && !bus.FIFOfull) ? eg : '0;
    chk("mdl_grant", bus.Grant, eg);
    chk("mdl_ack", bus.Ack, ea);
    chk("mdl_wrreq", bus.WRreq, ew);
    chk("mdl_wrdata", bus.WRdata, ed);
    chk("mdl_ptr", dut.ptr, m_ptr);
    model_next(req_v, bus.FIFOfull);
    ack_obs = bus.Ack;
  endtask

  task automatic tick_post();
    @(posedge WRclk);
    m_owner = nx_owner;
    m_ptr   = nx_ptr;
    m_cnt   = nx_cnt;
    for (int i = 0; i < N; i++) begin
      if (ack_obs[i] && rem[i] > 0) begin
        rem[i]--;
        dat[i]++;
        ack_cnt[i]++;
      end
    end
    @(negedge WRclk);
  endtask

  task automatic tick();
    tick_pre();
    tick_post();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    bus.FIFOfull = 1'b0;
    while (busy() && n < limit) begin
      tick();
      n++;
    end
    chk("drain_timeout", busy(), 0);
  endtask

  task automatic clear_acks();
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.FIFOfull = 1'b0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      dat[i] = '0;
    end
    clear_acks();
    model_reset();
    drive();
    repeat (2) @(negedge WRclk);
    reset = 1'b0;
    repeat (2) tick();

    // T1: reset asserted mid-burst clears outputs immediately
    rem[0] = 10;
    dat[0] = 8'h10;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t1_grant", bus.Grant, 0);
    chk("t1_wrreq", bus.WRreq, 0);
    chk("t1_ack", bus.Ack, 0);
    chk("t1_wrdata", bus.WRdata, 0);
    model_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 8;
      dat[i] = 8'(8'h20 * (i + 1));
    end
    @(negedge WRclk);
    reset = 1'b0;

    // T3: all requesting -> 4-word bursts rotate with no bubble
    clear_acks();
    tick();
    for (int k = 0; k < 17; k++) begin
      tick_pre();
      chk("t3_grant", bus.Grant, 32'(1) << ((k / 4) % 4));
      chk("t3_ack", bus.Ack, 32'(1) << ((k / 4) % 4));
      tick_post();
    end
    chk("t3_acks0", ack_cnt[0], 5);
    chk("t3_acks1", ack_cnt[1], 4);
    chk("t3_acks2", ack_cnt[2], 4);
    chk("t3_acks3", ack_cnt[3], 4);
    drain(300);

    // T2: lone requester is re-granted after MaxBurst words
    rem[2] = 6;
    dat[2] = 8'hA0;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick_pre();
      chk("t2_grant", bus.Grant, 4'b0100);
      chk("t2_ack", bus.Ack, 4'b0100);
      chk("t2_data", bus.WRdata, 8'hA0 + k);
      tick_post();
    end
    drain(50);

    // T4: FIFOfull stalls the burst without losing ownership
    clear_acks();
    rem[1] = 4;
    dat[1] = 8'h40;
    tick();
    repeat (2) begin
      tick_pre();
      chk("t4_grant", bus.Grant, 4'b0010);
      tick_post();
    end
    bus.FIFOfull = 1'b1;
    repeat (3) begin
      tick_pre();
      chk("t4_stall_ack", bus.Ack, 0);
      chk("t4_stall_wrreq", bus.WRreq, 1);
      chk("t4_stall_grant", bus.Grant, 4'b0010);
      tick_post();
    end
    bus.FIFOfull = 1'b0;
    repeat (2) begin
      tick_pre();
      chk("t4_grant", bus.Grant, 4'b0010);
      tick_post();
    end
    chk("t4_acks", ack_cnt[1], 4);
    drain(50);

    // T5: owner drops Req early, pending requester takes over on the next edge
    rem[1] = 2;
    dat[1] = 8'h50;
    tick();
    rem[3] = 3;
    dat[3] = 8'h70;
    repeat (2) tick();
    tick_pre();
    chk("t5_drop_grant", bus.Grant, 4'b0010);
    chk("t5_drop_ack", bus.Ack, 0);
    tick_post();
    tick_pre();
    chk("t5_grant", bus.Grant, 4'b1000);
    chk("t5_ptr", dut.ptr, 2);
    tick_post();
    drain(50);

    // T6: idle return and one-cycle grant latency from IDLE
    tick_pre();
    chk("t6_idle", bus.Grant, 0);
    tick_post();
    rem[0] = 1;
    dat[0] = 8'h60;
    tick();
    tick_pre();
    chk("t6_grant", bus.Grant, 4'b0001);
    chk("t6_ack", bus.Ack, 4'b0001);
    tick_post();
    drain(50);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
          rem[i] = $urandom_range(1, 7);
          dat[i] = W'($urandom);
        end
      end
      bus.FIFOfull = ($urandom_range(0, 3) == 0);
      tick();
    end
    drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
